// File: rtl/sync_dp_ram_be_if.sv
// Port bundle for sync_dp_ram_be: write port, read port, clear request and status.
// The master modport is the user side; the slave modport is the RAM itself.
interface sync_dp_ram_be_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                  clr_in;
  logic                  we_in;
  logic [ADDR_W-1:0]     wr_addr_in;
  logic [DATA_W/8-1:0]   wr_be_in;
  logic [DATA_W-1:0]     data_in;
  logic                  re_in;
  logic [ADDR_W-1:0]     rd_addr_in;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid_out;
  logic                  busy_out;

  modport master (
    output clr_in, we_in, wr_addr_in, wr_be_in, data_in, re_in, rd_addr_in,
    input  data_out, rd_valid_out, busy_out
  );

  modport slave (
    input  clr_in, we_in, wr_addr_in, wr_be_in, data_in, re_in, rd_addr_in,
    output data_out, rd_valid_out, busy_out
  );
endinterface

// File: rtl/sync_dp_ram_be.sv
// Simple dual-port RAM, one clock: byte-enabled write port, read port with
// selectable same-address behaviour, optional output register and a clear
// sequencer that zeroes the array after reset or on request.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | sweeping zeros through the array, one word per cycle; busy
// ST_RUN  | normal read/write service
module sync_dp_ram_be #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_dp_ram_be_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy;
  logic              port_ok;
  logic              wr_en;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_word;
  logic              rd_v1_q;
  logic [DATA_W-1:0] rd_d1_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign busy    = (state_q == ST_INIT);
  assign port_ok = (state_q == ST_RUN) && !bus.clr_in;
  assign wr_en   = port_ok && bus.we_in;
  assign rd_acc  = port_ok && bus.re_in;

  assign bus.busy_out = busy;

  // State and clear pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: sweep to the last word then run; a clear request restarts the sweep.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (bus.clr_in) begin
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.clr_in) begin
          state_d   = ST_INIT;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Array write: the clear sweep owns the write port while busy, else byte-masked user write.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.wr_be_in[k]) mem[bus.wr_addr_in][8*k +: 8] <= bus.data_in[8*k +: 8];
      end
    end
  end

  // Read word: stored value, or with write-first the stored value merged with this cycle's write.
  always_comb begin
    rd_word = mem[bus.rd_addr_in];
    if (RD_MODE == 1 && wr_en && (bus.wr_addr_in == bus.rd_addr_in)) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.wr_be_in[k]) rd_word[8*k +: 8] = bus.data_in[8*k +: 8];
      end
    end
  end

  // First read stage: captures accepted reads only, so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= rd_acc;
      if (rd_acc) rd_d1_q <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              rd_v2_q;
      logic [DATA_W-1:0] rd_d2_q;

      // Output stage: a clear request arriving while a read is in stage one drops that read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_v2_q <= 1'b0;
          rd_d2_q <= '0;
        end else begin
          rd_v2_q <= rd_v1_q && !bus.clr_in;
          if (rd_v1_q && !bus.clr_in) rd_d2_q <= rd_d1_q;
        end
      end

      assign bus.data_out     = rd_d2_q;
      assign bus.rd_valid_out = rd_v2_q;
    end else begin : g_no_out_reg
      assign bus.data_out     = rd_d1_q;
      assign bus.rd_valid_out = rd_v1_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_dp_ram_be.sv
// Bench for sync_dp_ram_be: two instances driven identically, one read-first
// without output register, one write-first with output register, both 16 bits wide.
module tb_sync_dp_ram_be;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  sync_dp_ram_be_if #(.DATA_W(16), .ADDR_W(4)) bus0 ();
  sync_dp_ram_be_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

  sync_dp_ram_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  sync_dp_ram_be #(.DATA_W(16), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [1:0] be,
                       input logic [15:0] d, input logic re, input logic [3:0] ra,
                       input logic clr);
    bus0.we_in = we; bus0.wr_addr_in = wa; bus0.wr_be_in = be; bus0.data_in = d;
    bus0.re_in = re; bus0.rd_addr_in = ra; bus0.clr_in = clr;
    bus1.we_in = we; bus1.wr_addr_in = wa; bus1.wr_be_in = be; bus1.data_in = d;
    bus1.re_in = re; bus1.rd_addr_in = ra; bus1.clr_in = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus0.busy_out || bus1.busy_out) && n < 40) begin
      cyc();
      n++;
    end
    chk(name, n, 16);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b1, a, be, d, 1'b0, 4'd0, 1'b0);
    cyc();
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e0, input logic [15:0] e1);
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, a, 1'b0);
    q0.push_back(e0);
    q1.push_back(e1);
    cyc();
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, 16'h0000);
    idle(3);
  endtask

  // Scoreboard monitors: every read-valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (bus0.rd_valid_out) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_valid actual=1 required=0 data=%0h", bus0.data_out);
      end else chk("dut0_read_data", bus0.data_out, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus1.rd_valid_out) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_valid actual=1 required=0 data=%0h", bus1.data_out);
      end else chk("dut1_read_data", bus1.data_out, q1.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("rst_data0", bus0.data_out, 0);
    chk("rst_data1", bus1.data_out, 0);
    chk("rst_valid", {bus0.rd_valid_out, bus1.rd_valid_out}, 0);
    chk("rst_busy", {bus0.busy_out, bus1.busy_out}, 2'b11);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: init sweep length, then all words zero
    wait_idle("init_busy_cycles");
    read_all_zero();

    // 2: write then read with latency and hold
    wr(4'd3, 16'h00A5, 2'b11);
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd3, 1'b0);
    q0.push_back(16'h00A5); q1.push_back(16'h00A5);
    cyc();
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("lat_dut0_edge1", {bus0.rd_valid_out, bus0.data_out}, {1'b1, 16'h00A5});
    chk("lat_dut1_edge1", bus1.rd_valid_out, 0);
    cyc();
    chk("lat_dut0_edge2", bus0.rd_valid_out, 0);
    chk("lat_dut1_edge2", {bus1.rd_valid_out, bus1.data_out}, {1'b1, 16'h00A5});
    cyc(); cyc();
    chk("hold_valid", {bus0.rd_valid_out, bus1.rd_valid_out}, 0);
    chk("hold_data0", bus0.data_out, 16'h00A5);
    chk("hold_data1", bus1.data_out, 16'h00A5);

    // 3: same-address read during write, full word
    wr(4'd5, 16'h0011, 2'b11);
    drive(1'b1, 4'd5, 2'b11, 16'h0022, 1'b1, 4'd5, 1'b0);
    q0.push_back(16'h0011); q1.push_back(16'h0022);
    cyc();
    rd(4'd5, 16'h0022, 16'h0022);
    idle(3);

    // 4: byte enables, including a partial same-address read during write
    wr(4'd2, 16'h1234, 2'b11);
    wr(4'd2, 16'hABCD, 2'b01);
    rd(4'd2, 16'h12CD, 16'h12CD);
    wr(4'd2, 16'hFFFF, 2'b00);
    rd(4'd2, 16'h12CD, 16'h12CD);
    wr(4'd2, 16'h56EE, 2'b10);
    rd(4'd2, 16'h56CD, 16'h56CD);
    drive(1'b1, 4'd2, 2'b01, 16'h7788, 1'b1, 4'd2, 1'b0);
    q0.push_back(16'h56CD); q1.push_back(16'h5688);
    cyc();
    drive(1'b1, 4'd9, 2'b11, 16'h0909, 1'b1, 4'd2, 1'b0);
    q0.push_back(16'h5688); q1.push_back(16'h5688);
    cyc();
    rd(4'd9, 16'h0909, 16'h0909);
    rd(4'd2, 16'h5688, 16'h5688);
    idle(3);

    // 5: fill, clear with a read in flight and one in the clear cycle
    for (int a = 0; a < 16; a++) wr(4'(a), 16'(a), 2'b11);
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 1'b0);
    q0.push_back(16'h0007);
    cyc();
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd8, 1'b1);
    cyc();
    drive(1'b1, 4'd9, 2'b11, 16'hFFFF, 1'b1, 4'd9, 1'b0);
    chk("clr_busy", {bus0.busy_out, bus1.busy_out}, 2'b11);
    chk("clr_dut1_hold", bus1.data_out, 16'h5688);
    wait_idle("clr_busy_cycles");
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("clr_dut0_hold", bus0.data_out, 16'h0007);
    chk("clr_dut1_hold_after", bus1.data_out, 16'h5688);
    read_all_zero();

    // 6: async reset during a write burst with reads in flight
    wr(4'd4, 16'hBEEF, 2'b11);
    drive(1'b1, 4'd6, 2'b11, 16'h6666, 1'b1, 4'd4, 1'b0);
    cyc();
    chk("pre_rst_dut0", {bus0.rd_valid_out, bus0.data_out}, {1'b1, 16'hBEEF});
    drive(1'b1, 4'd7, 2'b11, 16'h7777, 1'b1, 4'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data0", bus0.data_out, 0);
    chk("mid_rst_data1", bus1.data_out, 0);
    chk("mid_rst_valid", {bus0.rd_valid_out, bus1.rd_valid_out}, 0);
    chk("mid_rst_busy", {bus0.busy_out, bus1.busy_out}, 2'b11);
    drive(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 1'b0);
    cyc(); cyc();
    rst = 1'b0;
    wait_idle("rst_again_busy_cycles");
    read_all_zero();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
